// File: rtl/keys_edge_pio_pkg.sv
// keys_edge_pio_pkg: register addresses, edge-type encoding and bus width shared by the input PIO.
package keys_edge_pio_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_ANY} edge_type_e;
endpackage

// File: rtl/keys_pio_debounce.sv
// keys_pio_debounce: single-bit debouncer; q follows d only after d has differed for DEBOUNCE_CYCLES cycles.
module keys_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/keys_edge_pio.sv
// keys_edge_pio: Avalon-MM input PIO with synchronizer, edge capture (W1C) and maskable level irq.
// Optional per-bit debouncer enabled by defining KEYS_EDGE_PIO_DEBOUNCE_EN.
module keys_edge_pio
  import keys_edge_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);
  logic [WIDTH-1:0] sync1, sync2, filt, prev, irq_mask, edge_capture;
  logic [WIDTH-1:0] rise, fall, det, clr;
  logic [DATA_W-1:0] rd;
  logic wr;
  logic unused;
  assign unused = ^writedata ^ (DEBOUNCE_CYCLES != 0);
`ifdef KEYS_EDGE_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    keys_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset_n(reset_n), .d(sync2[i]), .q(filt[i])
    );
  end
`else
  assign filt = sync2;
`endif
  assign rise = filt & ~prev;
  assign fall = ~filt & prev;
  assign det  = EDGE_TYPE == int'(EDGE_RISE) ? rise :
                EDGE_TYPE == int'(EDGE_FALL) ? fall : rise | fall;
  assign wr   = chipselect & ~write_n;
  assign clr  = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign rd   = address == ADDR_DATA ? DATA_W'(filt) :
                address == ADDR_MASK ? DATA_W'(irq_mask) :
                address == ADDR_EDGE ? DATA_W'(edge_capture) : '0;
  assign irq  = |(edge_capture & irq_mask);
  // a new edge in the same cycle as its W1C keeps the bit set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      sync1        <= in_port;
      sync2        <= sync1;
      prev         <= filt;
      irq_mask     <= (wr && address == ADDR_MASK) ? writedata[WIDTH-1:0] : irq_mask;
      edge_capture <= (edge_capture & ~clr) | det;
      readdata     <= rd;
    end
  end
endmodule

// File: tb/tb_keys_edge_pio.sv
// tb_keys_edge_pio: table-driven directed vectors plus randomized traffic checked against a sample-history model.
module tb_keys_edge_pio;
  import keys_edge_pio_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] address = '0;
  logic chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0] in_port = 4'hF;
  logic [31:0] readdata;
  logic irq;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  keys_edge_pio #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // Model: smp[k] is the in_port value sampled at the k-th edge after reset.
  // The filtered level seen after edge m is smp[m-1]; prev is one sample older.
  logic [3:0] smp [0:1023];
  int n = 0;
  logic [3:0] m_cap = '0, m_mask = '0;
  logic [31:0] m_rd = '0;
  function automatic logic [3:0] s(input int k);
    return k < 1 ? 4'h0 : smp[k];
  endfunction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n <= 0;
      m_cap <= '0;
      m_mask <= '0;
      m_rd <= '0;
    end else begin
      m_rd <= address == 2'd0 ? {28'h0, s(n - 1)} : address == 2'd2 ? {28'h0, m_mask} :
              address == 2'd3 ? {28'h0, m_cap} : 32'h0;
      m_cap <= (m_cap & ~((chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0))
               | (~s(n - 1) & s(n - 2));
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[3:0];
      smp[(n + 1) % 1024] <= in_port;
      n <= n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] i, input logic cs, input logic wn,
                       input logic [1:0] a, input logic [31:0] wd);
    in_port = i; chipselect = cs; write_n = wn; address = a; writedata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [3:0] in; logic cs; logic wn; logic [1:0] a; logic [31:0] wd;
    logic [31:0] rd; logic irq;
  } vec_t;
  vec_t tbl [32];

  initial begin
    tbl[0]  = '{4'hF, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0};
    tbl[2]  = '{4'hF, 1'b0, 1'b1, 2'd0, 32'h0, 32'hF, 1'b0};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 2'd2, 32'h2, 32'h0, 1'b0};
    tbl[4]  = '{4'hD, 1'b0, 1'b1, 2'd2, 32'h0, 32'h2, 1'b0};
    tbl[5]  = '{4'hD, 1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0};
    tbl[6]  = '{4'hD, 1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1'b1};
    tbl[7]  = '{4'hD, 1'b0, 1'b1, 2'd3, 32'h0, 32'h2, 1'b1};
    tbl[8]  = '{4'hD, 1'b1, 1'b0, 2'd3, 32'h2, 32'h2, 1'b0};
    tbl[9]  = '{4'hF, 1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0};
    tbl[10] = '{4'hF, 1'b0, 1'b1, 2'd0, 32'h0, 32'hD, 1'b0};
    tbl[11] = '{4'hD, 1'b0, 1'b1, 2'd0, 32'h0, 32'hF, 1'b0};
    tbl[12] = '{4'hD, 1'b0, 1'b1, 2'd0, 32'h0, 32'hF, 1'b0};
    tbl[13] = '{4'hD, 1'b1, 1'b0, 2'd3, 32'h2, 32'h0, 1'b1};
    tbl[14] = '{4'hD, 1'b0, 1'b1, 2'd3, 32'h0, 32'h2, 1'b1};
    tbl[15] = '{4'hD, 1'b1, 1'b0, 2'd2, 32'h0, 32'h2, 1'b0};
    tbl[16] = '{4'hC, 1'b1, 1'b0, 2'd3, 32'hF, 32'h2, 1'b0};
    tbl[17] = '{4'hC, 1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0};
    tbl[18] = '{4'hC, 1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1'b0};
    tbl[19] = '{4'hC, 1'b0, 1'b1, 2'd3, 32'h0, 32'h1, 1'b0};
    tbl[20] = '{4'hC, 1'b1, 1'b0, 2'd2, 32'h1, 32'h0, 1'b1};
    tbl[21] = '{4'hC, 1'b1, 1'b0, 2'd2, 32'h0, 32'h1, 1'b0};
    tbl[22] = '{4'hC, 1'b0, 1'b1, 2'd3, 32'h0, 32'h1, 1'b0};
    tbl[23] = '{4'hC, 1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, 1'b0};
    tbl[24] = '{4'hC, 1'b1, 1'b0, 2'd0, 32'hFFFFFFFF, 32'hC, 1'b0};
    tbl[25] = '{4'hC, 1'b0, 1'b1, 2'd3, 32'h0, 32'h1, 1'b0};
    tbl[26] = '{4'hC, 1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 1'b0};
    tbl[27] = '{4'hC, 1'b1, 1'b0, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b1};
    tbl[28] = '{4'hC, 1'b0, 1'b1, 2'd2, 32'h0, 32'hF, 1'b1};
    tbl[29] = '{4'hC, 1'b1, 1'b0, 2'd2, 32'h0, 32'hF, 1'b0};
    tbl[30] = '{4'hC, 1'b0, 1'b0, 2'd2, 32'hF, 32'h0, 1'b0};
    tbl[31] = '{4'hC, 1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
`ifdef KEYS_EDGE_PIO_DEBOUNCE_EN
    drive(4'hF, 1'b0, 1'b1, 2'd0, 32'h0);
    repeat (15) step();
    drive(4'hF, 1'b1, 1'b0, 2'd2, 32'h1);
    step();
    drive(4'hE, 1'b0, 1'b1, 2'd3, 32'h0);
    repeat (5) step();
    in_port = 4'hF;
    repeat (20) step();
    chk("glitch_capture", readdata, 32'h0);
    chk("glitch_irq", {31'h0, irq}, 32'h0);
    in_port = 4'hE;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 10) chk("db_irq_early", {31'h0, irq}, 32'h0);
      if (i == 11) chk("db_irq_on_time", {31'h0, irq}, 32'h1);
    end
    step();
    chk("db_capture", readdata, 32'h1);
`else
    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].in, tbl[i].cs, tbl[i].wn, tbl[i].a, tbl[i].wd);
      step();
      chk($sformatf("vec%0d_readdata", i), readdata, tbl[i].rd);
      chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].irq});
    end
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset_n = 1'b0;
        #1;
        chk("midreset_readdata", readdata, 32'h0);
        chk("midreset_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
      end
      drive(in_port ^ (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0),
            1'($urandom), 1'($urandom), 2'($urandom), $urandom);
      step();
      chk("rand_readdata", readdata, m_rd);
      chk("rand_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
